// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver: time-multiplexed 4-digit 7-segment scan with anti-ghosting blank window
module seven_seg_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value_i,
    input  logic [3:0]  dp_i,
    input  logic        load_i,
    input  logic        en_i,
    output logic        sel_A,
    output logic        sel_B,
    output logic [6:0]  seg_n,
    output logic        dp_n
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [15:0]     shadow_val_q;
    logic [3:0]      shadow_dp_q;
    logic [3:0]      nib;
    logic [6:0]      hex;

    // Next-state: dark idle, blank window, lit remainder of slot; disable always wins
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (en_i) state_d = BLANK;
            end
            BLANK: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == BLANK_LAST) state_d = SHOW;
            end
            SHOW: begin
                cnt_d   = (cnt_q == SLOT_LAST) ? '0 : cnt_q + 1'b1;
                idx_d   = (cnt_q == SLOT_LAST) ? idx_q + 1'b1 : idx_q;
                state_d = (cnt_q == SLOT_LAST) ? BLANK : SHOW;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase
        if (!en_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // Scan state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    // Shadow copy of the display value, loadable regardless of scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val_q <= '0;
            shadow_dp_q  <= '0;
        end else if (load_i) begin
            shadow_val_q <= value_i;
            shadow_dp_q  <= dp_i;
        end
    end

    // Hex-to-segment decode of the selected nibble (gfedcba, active low)
    always_comb begin
        nib = shadow_val_q[{idx_q, 2'b00} +: 4];
        case (nib)
            4'h0: hex = 7'h40;
            4'h1: hex = 7'h79;
            4'h2: hex = 7'h24;
            4'h3: hex = 7'h30;
            4'h4: hex = 7'h19;
            4'h5: hex = 7'h12;
            4'h6: hex = 7'h02;
            4'h7: hex = 7'h78;
            4'h8: hex = 7'h00;
            4'h9: hex = 7'h10;
            4'hA: hex = 7'h08;
            4'hB: hex = 7'h03;
            4'hC: hex = 7'h46;
            4'hD: hex = 7'h21;
            4'hE: hex = 7'h06;
            default: hex = 7'h0E;
        endcase
    end

    assign {sel_A, sel_B} = idx_q;
    assign seg_n          = (state_q == SHOW) ? hex : 7'h7F;
    assign dp_n           = (state_q == SHOW) ? ~shadow_dp_q[idx_q] : 1'b1;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb_seven_seg_scan_driver: randomized scoreboard bench against a slot-timing reference model
module tb_seven_seg_scan_driver;
    localparam int RD = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0;
    logic        load_i = 1'b0;
    logic        en_i = 1'b0;
    logic        sel_A, sel_B, dp_n;
    logic [6:0]  seg_n;

    seven_seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .rst_n(rst_n), .value_i(value_i), .dp_i(dp_i),
        .load_i(load_i), .en_i(en_i), .sel_A(sel_A), .sel_B(sel_B),
        .seg_n(seg_n), .dp_n(dp_n)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q [$];

    // Reference model: time since enable determines digit and whether the slot is still dark
    bit          m_run = 0;
    int          m_t = 0;
    int          m_idx = 0;
    int          m_p = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;

    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got sel=%b seg=%h dp=%b want sel=%b seg=%h dp=%b",
                     name, $time, act[9:8], act[7:1], act[0], exp[9:8], exp[7:1], exp[0]);
        end
    endtask

    function automatic logic [9:0] dut_out();
        return {sel_A, sel_B, seg_n, dp_n};
    endfunction

    initial forever begin
        bit dark;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_run = 0; m_t = 0; m_idx = 0; m_p = 0; m_val = '0; m_dp = '0;
            exp_q.delete();
        end else begin
            if (!en_i) m_run = 0;
            else if (!m_run) begin m_run = 1; m_t = 0; end
            else m_t++;
            if (load_i) begin m_val = value_i; m_dp = dp_i; end
            m_idx = m_run ? (m_t / RD) % 4 : 0;
            m_p   = m_t % RD;
            dark  = !m_run || m_p < BL;
            exp_q.push_back({2'(m_idx), dark ? 7'h7F : hex_t[m_val[4*m_idx +: 4]],
                             dark ? 1'b1 : ~m_dp[m_idx]});
        end
    end

    // Monitor: every cycle the DUT presents a display state; compare against the queue head
    initial forever begin
        @(posedge clk);
        #1;
        if (rst_n && exp_q.size() > 0) chk("scan", dut_out(), exp_q.pop_front());
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        #1 chk("reset_init", dut_out(), {2'b00, 7'h7F, 1'b1});
        cycles(2);
        rst_n = 1'b1;
        cycles(2);
        // digits 0..3 = F, A, 2, 1 with dp on digit1; run over a full wrap
        value_i = 16'h12AF; dp_i = 4'b0010; load_i = 1'b1; en_i = 1'b1;
        cycles(1);
        load_i = 1'b0;
        cycles(40);
        // async reset in the middle of digit 2's lit window
        for (k = 0; k < 100 && !(m_run && m_idx == 2 && m_p >= BL); k++) cycles(1);
        if (k == 100) chk("wait_idx2", 10'h0, 10'h3FF);
        #2 rst_n = 1'b0;
        en_i = 1'b0;
        #1 chk("reset_async", dut_out(), {2'b00, 7'h7F, 1'b1});
        cycles(2);
        rst_n = 1'b1;
        en_i = 1'b1;
        cycles(20);
        // disable at the third lit cycle of digit 1, then re-enable
        for (k = 0; k < 100 && !(m_run && m_idx == 1 && m_p == BL + 2); k++) cycles(1);
        if (k == 100) chk("wait_idx1", 10'h0, 10'h3FF);
        value_i = 16'h12AF; load_i = 1'b1; en_i = 1'b0;
        cycles(1);
        load_i = 1'b0;
        cycles(3);
        en_i = 1'b1;
        cycles(12);
        // reload mid-lit window of digit 0
        for (k = 0; k < 100 && !(m_run && m_idx == 0 && m_p == BL + 1); k++) cycles(1);
        if (k == 100) chk("wait_idx0", 10'h0, 10'h3FF);
        value_i = 16'h0005; dp_i = 4'b0000; load_i = 1'b1;
        cycles(1);
        load_i = 1'b0;
        cycles(10);
        // load while dark, then enable
        en_i = 1'b0;
        cycles(2);
        value_i = 16'hBEEF; dp_i = 4'b1001; load_i = 1'b1;
        cycles(1);
        load_i = 1'b0;
        cycles(3);
        en_i = 1'b1;
        cycles(36);
        // random traffic
        for (int i = 0; i < 800; i++) begin
            en_i    = ($urandom_range(0, 24) != 0);
            load_i  = ($urandom_range(0, 9) == 0);
            value_i = 16'($urandom);
            dp_i    = 4'($urandom);
            cycles(1);
        end
        load_i = 1'b0;
        cycles(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
